// File: rtl/exibidor_sequencia.sv
// Memory-game sequence player: reads entries 0..rodada from the sequence RAM and
// flashes each one on the LEDs for T_ACESO cycles, then blanks them for T_APAGADO cycles.
module exibidor_sequencia #(
  parameter int T_ACESO   = 500,
  parameter int T_APAGADO = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] rodada,
  input  logic [3:0] dado_memoria,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       fim,
  output logic [3:0] db_estado
);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    LEITURA_A = 3'd1,
    LEITURA_B = 3'd2,
    ACESO     = 3'd3,
    APAGADO   = 3'd4,
    FIM       = 3'd5
  } estado_t;

  estado_t     estado, proximo;
  logic [15:0] timer;
  logic [3:0]  rodada_q;
  logic        fim_aceso, fim_apagado, ultimo;

  assign fim_aceso   = (timer == 16'(T_ACESO - 1));
  assign fim_apagado = (timer == 16'(T_APAGADO - 1));
  assign ultimo      = (endereco == rodada_q);

  assign ocupado   = (estado != OCIOSO);
  assign db_estado = {1'b0, estado};

  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO:    if (iniciar) proximo = LEITURA_A;
      LEITURA_A: proximo = LEITURA_B;
      LEITURA_B: proximo = ACESO;
      ACESO:     if (fim_aceso) proximo = APAGADO;
      APAGADO:   if (fim_apagado) proximo = ultimo ? FIM : LEITURA_A;
      FIM:       proximo = OCIOSO;
      default:   proximo = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) estado <= OCIOSO;
    else       estado <= proximo;
  end

  // Datapath registers; leds and fim are registered so the player never sees glitches.
  always_ff @(posedge clock) begin
    if (reset) begin
      endereco <= '0;
      leds     <= '0;
      timer    <= '0;
      rodada_q <= '0;
      fim      <= 1'b0;
    end else begin
      fim <= (proximo == FIM);
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            rodada_q <= rodada;
            endereco <= '0;
          end
        end
        LEITURA_B: begin
          leds  <= dado_memoria;
          timer <= '0;
        end
        ACESO: begin
          if (fim_aceso) begin
            timer <= '0;
            leds  <= '0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        APAGADO: begin
          if (fim_apagado) begin
            timer <= '0;
            // Equality stop at the latched round keeps endereco from wrapping past 15.
            if (!ultimo) endereco <= endereco + 4'd1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Bench for exibidor_sequencia: a per-cycle expected trace is generated from the
// playback rules (entry list + durations) and compared against the DUT every cycle.
module tb_exibidor_sequencia;
  localparam int TA = 4;
  localparam int TO = 2;

  logic       clock = 1'b0;
  logic       reset, iniciar;
  logic [3:0] rodada, dado_memoria, endereco, leds, db_estado;
  logic       ocupado, fim;
  logic [3:0] ram [16];

  int n_chk  = 0;
  int n_fail = 0;
  int q_st[$], q_addr[$], q_led[$];

  exibidor_sequencia #(.T_ACESO(TA), .T_APAGADO(TO)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .rodada(rodada),
    .dado_memoria(dado_memoria), .endereco(endereco), .leds(leds),
    .ocupado(ocupado), .fim(fim), .db_estado(db_estado)
  );

  always #5 clock = ~clock;
  assign dado_memoria = ram[endereco];

  // Expected trace starting the cycle after iniciar is sampled.
  task automatic build_model(input int r);
    q_st.delete(); q_addr.delete(); q_led.delete();
    for (int e = 0; e <= r; e++) begin
      q_st.push_back(1); q_addr.push_back(e); q_led.push_back(0);
      q_st.push_back(2); q_addr.push_back(e); q_led.push_back(0);
      repeat (TA) begin q_st.push_back(3); q_addr.push_back(e); q_led.push_back(int'(ram[e])); end
      repeat (TO) begin q_st.push_back(4); q_addr.push_back(e); q_led.push_back(0); end
    end
    q_st.push_back(5); q_addr.push_back(r); q_led.push_back(0);
    q_st.push_back(0); q_addr.push_back(r); q_led.push_back(0);
  endtask

  task automatic test_reset();
    logic [13:0] got;
    reset = 1'b1; iniciar = 1'b0; rodada = 4'd0;
    repeat (2) @(negedge clock);
    got = {db_estado, endereco, leds, fim, ocupado};
    n_chk++;
    if (got !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", got, 14'h0);
    end
    reset = 1'b0;
    iniciar = 1'b0;
    repeat (3) @(negedge clock);
    got = {db_estado, endereco, leds, fim, ocupado};
    n_chk++;
    if (got !== 14'h0) begin
      n_fail++;
      $display("FAIL idle_after_reset got=%h exp=%h", got, 14'h0);
    end
  endtask

  // glitch_at >= 0 pulses iniciar and changes rodada to 5 mid-play at that trace index.
  task automatic test_playback(input string name, input int r, input int glitch_at);
    logic [13:0] got, exp;
    build_model(r);
    @(negedge clock); iniciar = 1'b1; rodada = 4'(r);
    @(negedge clock); iniciar = 1'b0;
    for (int i = 0; i < q_st.size(); i++) begin
      got = {db_estado, endereco, leds, fim, ocupado};
      exp = {4'(q_st[i]), 4'(q_addr[i]), 4'(q_led[i]), q_st[i] == 5, q_st[i] != 0};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s cyc=k+%0d {st,addr,leds,fim,ocup} got=%h exp=%h", name, i + 1, got, exp);
      end
      if (i == glitch_at) begin iniciar = 1'b1; rodada = 4'd5; end
      else if (i == glitch_at + 1) iniciar = 1'b0;
      @(negedge clock);
    end
    iniciar = 1'b0;
  endtask

  task automatic test_abort();
    logic [13:0] got, exp;
    int ab;
    for (int j = 0; j < 16; j++) ram[j] = 4'($urandom_range(1, 15));
    build_model(3);
    ab = (2 + TA + TO) + 2 + 1;  // mid-ACESO of entry 1
    @(negedge clock); iniciar = 1'b1; rodada = 4'd3;
    @(negedge clock); iniciar = 1'b0;
    for (int i = 0; i <= ab; i++) begin
      got = {db_estado, endereco, leds, fim, ocupado};
      exp = {4'(q_st[i]), 4'(q_addr[i]), 4'(q_led[i]), q_st[i] == 5, q_st[i] != 0};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL abort_pre cyc=k+%0d got=%h exp=%h", i + 1, got, exp);
      end
      if (i < ab) @(negedge clock);
    end
    reset = 1'b1;
    @(negedge clock);
    got = {db_estado, endereco, leds, fim, ocupado};
    n_chk++;
    if (got !== 14'h0) begin
      n_fail++;
      $display("FAIL abort_reset got=%h exp=%h", got, 14'h0);
    end
    reset = 1'b0;
    test_playback("abort_replay", int'($urandom_range(1, 4)), -1);
  endtask

  task automatic test_hold_iniciar();
    logic [13:0] got, exp;
    for (int j = 0; j < 16; j++) ram[j] = 4'($urandom_range(0, 15));
    build_model(1);
    @(negedge clock); iniciar = 1'b1; rodada = 4'd1;
    @(negedge clock);
    for (int i = 0; i < q_st.size(); i++) begin
      got = {db_estado, endereco, leds, fim, ocupado};
      exp = {4'(q_st[i]), 4'(q_addr[i]), 4'(q_led[i]), q_st[i] == 5, q_st[i] != 0};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL hold cyc=k+%0d got=%h exp=%h", i + 1, got, exp);
      end
      @(negedge clock);
    end
    got = {db_estado, endereco, leds, fim, ocupado};
    exp = {4'd1, 4'd0, 4'd0, 1'b0, 1'b1};
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL hold_restart got=%h exp=%h", got, exp);
    end
    iniciar = 1'b0; reset = 1'b1;
    @(negedge clock); reset = 1'b0;
  endtask

  initial begin
    int r;
    for (int j = 0; j < 16; j++) ram[j] = 4'd0;
    test_reset();

    ram[0] = 4'd1; ram[1] = 4'd2; ram[2] = 4'd4; ram[3] = 4'd8;
    test_playback("basic_r2", 2, -1);

    ram[0] = 4'd8;
    test_playback("single_r0", 0, -1);

    for (int j = 0; j < 16; j++) ram[j] = 4'(j);
    test_playback("full_r15", 15, -1);

    ram[0] = 4'd1; ram[1] = 4'd2; ram[2] = 4'd4;
    test_playback("glitch_r2", 2, 2 + TA + 1);

    test_abort();

    for (int t = 0; t < 6; t++) begin
      for (int j = 0; j < 16; j++) ram[j] = 4'($urandom_range(0, 15));
      ram[1] = 4'd0;
      r = int'($urandom_range(0, 15));
      test_playback("random", r, -1);
    end

    test_hold_iniciar();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/exibidor_sequencia.md
Name: exibidor_sequencia

Overview:
Plays back the stored button sequence of the memory game on the LEDs, from entry 0 up to the current round. It reads the sequence RAM through an address/data port, lights each entry for a fixed on-time, then blanks for a fixed off-time. It is the transmit side of the player interface: the game reads `botoes` from the player, and this block writes `leds` to the player. The game control unit starts it with a one-cycle `iniciar` pulse and waits for the `fim` pulse before enabling player input.

Parameters:
T_ACESO, 500, cycles each entry is shown on leds (1..65535)
T_APAGADO, 250, cycles leds stay blank after each entry (1..65535)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
iniciar  input  1  start pulse; sampled only in OCIOSO
rodada  input  4  index of last entry to show (shows entries 0..rodada inclusive)
dado_memoria  input  4  sequence RAM read data
endereco  output  4  sequence RAM read address
leds  output  4  one-hot-or-any pattern presented to player
ocupado  output  1  high in every state except OCIOSO
fim  output  1  one-cycle pulse when playback completes
db_estado  output  4  current state code, for the hexa7seg debug display

Behaviour:
Reset values and reset rules:
- On reset: state OCIOSO, `endereco`=0, `leds`=0, `ocupado`=0, `fim`=0, timer=0, latched round=0.
- Reset has priority over every other input in every state.
- A reset mid-playback aborts immediately: the next cycle is OCIOSO with `leds` blank and no `fim` pulse.

State codes (on `db_estado`): OCIOSO=0, LEITURA_A=1, LEITURA_B=2, ACESO=3, APAGADO=4, FIM=5.

Transitions:
- OCIOSO: if `iniciar`=1, then `rodada` is latched into an internal register, `endereco`←0, and the next state is LEITURA_A. Otherwise stay.
- LEITURA_A: 1 cycle, holds `endereco`, then go to LEITURA_B. The two read cycles make the block correct for both combinational RAM and RAM with a registered address.
- LEITURA_B: 1 cycle. On exit, `dado_memoria` is captured into the LED register, timer←0, and the next state is ACESO.
- ACESO: `leds` = captured value, held for exactly T_ACESO cycles (timer counts 0..T_ACESO-1). On the last cycle, timer←0 and the next state is APAGADO.
- APAGADO: `leds`=0 for exactly T_APAGADO cycles. On the last cycle:
  - if `endereco` == latched round, go to FIM;
  - else `endereco`←`endereco`+1 and go to LEITURA_A.
- FIM: 1 cycle with `fim`=1 and `leds`=0, then go to OCIOSO.

Rules and boundary conditions:
- `leds` is 0 in every state except ACESO. It is driven from a register, so it is glitch-free.
- `iniciar` is ignored while `ocupado`=1; there is no restart mid-playback.
- `iniciar` held high continuously restarts playback one cycle after FIM, because OCIOSO is entered and `iniciar` is sampled there.
- `rodada` changes after start have no effect.
- Latency: with `iniciar` sampled at edge k, LEITURA_A occupies cycle k+1 and `fim` is high in cycle k+1+(rodada+1)·(2+T_ACESO+T_APAGADO).
- `rodada`=0 shows exactly one entry.
- `rodada`=15 shows all 16 entries. `endereco` never wraps because the equality check ends playback at 15.
- An entry value of 0 is shown as blank LEDs for the full T_ACESO. There is no skipping.
- Timer is 16 bits and wraps only via explicit clears.

Test Plan:
1. Use T_ACESO=4, T_APAGADO=2, RAM = {1,2,4,8}, `rodada`=2, and pulse `iniciar` at edge k. Required response:
   - `endereco` steps 0,1,2;
   - `leds` shows 1, 2, 4, each for 4 cycles, separated by 2 blank cycles;
   - `fim`=1 only in cycle k+25;
   - `ocupado` is high from k+1 through k+25.
2. With `rodada`=0 and RAM[0]=8: `leds`=8 for 4 cycles, then `fim` at k+9. `endereco` stays 0 throughout.
3. With `rodada`=15 and RAM[i]=i: all 16 values appear in order, `endereco` ends at 15 with no wrap, and `fim` arrives at k+129.
4. Assert `reset`=1 during the ACESO of entry 1. Next cycle: `db_estado`=0, `leds`=0, `endereco`=0, `ocupado`=0, and no `fim`. A fresh `iniciar` then replays from entry 0.
5. Pulse `iniciar` again during APAGADO and change `rodada` to 5 mid-play. Neither has any effect: the original 3-entry playback and `fim` timing are unchanged.
6. Check the `db_estado` sequence 0,1,2,3,3,3,3,4,4,1,… and that `leds` is never nonzero outside state 3.
